// File: rtl/ifetch_prefetch.sv
// Sequential instruction prefetch buffer with flush/redirect on non-sequential fetch.
// Optional IFETCH_PERF_EN adds saturating flush and miss counters.
module ifetch_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        i_req_i,
    input  logic [31:0] i_addr_i,
    output logic        i_valid_o,
    output logic [31:0] i_data_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] flush_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    localparam int          PW      = $clog2(DEPTH);
    localparam int          CW      = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]   fifo [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, inflight, discard;
    logic [31:0]   fetch_pc, head_pc;
    logic [CW:0]   occ;
    logic          flush, hit, grant, push, drop;

    assign flush = i_req_i && (i_addr_i != head_pc);
    assign hit   = i_req_i && (count != '0) && (i_addr_i == head_pc);
    assign occ   = {1'b0, count} + {1'b0, inflight} + {1'b0, discard};

    // Reset gating keeps the memory port quiet while rst_n_i is low.
    assign mem_req_o  = rst_n_i && !flush && (occ < DEPTH_W);
    assign mem_addr_o = fetch_pc;
    assign grant      = mem_req_o && mem_gnt_i;

    // Responses in a flush cycle are always stale, so neither push nor drop applies.
    assign push = mem_rvalid_i && !flush && (discard == '0);
    assign drop = mem_rvalid_i && !flush && (discard != '0);

    assign i_valid_o = hit;
    assign i_data_o  = hit ? fifo[rd_ptr] : 32'h0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fetch_pc <= RESET_PC;
            head_pc  <= RESET_PC;
        end else if (flush) begin
            count    <= '0;
            inflight <= '0;
            discard  <= discard + inflight - CW'(mem_rvalid_i);
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fetch_pc <= i_addr_i;
            head_pc  <= i_addr_i;
        end else begin
            if (grant) fetch_pc <= fetch_pc + 32'd4;
            if (hit) begin
                head_pc <= head_pc + 32'd4;
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (drop) discard <= discard - 1'b1;
            count    <= count + CW'(push) - CW'(hit);
            inflight <= inflight + CW'(grant) - CW'(push);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo[wr_ptr] <= mem_rdata_i;
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            flush_cnt_o <= '0;
            miss_cnt_o  <= '0;
        end else begin
            if (flush && flush_cnt_o != 32'hFFFF_FFFF) flush_cnt_o <= flush_cnt_o + 32'd1;
            if (i_req_i && !i_valid_o && miss_cnt_o != 32'hFFFF_FFFF) miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(push && count == CW'(DEPTH)));
    a_aligned: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        i_req_i |-> (i_addr_i[1:0] == 2'b00));

endmodule
